// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Resolves a conditional branch. A request (condition code, branch PC, word
// offset) is accepted in IDLE. The unit then waits WAIT_CYC cycles so that the
// ALU status (Z, N, V) of the compare issued in the same cycle has settled.
// The ALU updates those flags on the falling clock edge. The unit samples
// them on one rising edge and then evaluates the condition. It returns
// taken / next PC / error over a valid/ready response.
//
// Handshake semantics (both directions): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that transfer. req_ready is high only in IDLE. A
// response transfer returns the unit to IDLE, so the next request can be
// accepted no earlier than the following edge. resp_ready is ignored unless a
// response is pending.
//
// Optional feature macro: BCU_STATS_EN. When it is defined, the saturating
// counters stat_req and stat_taken are added.
//
// Parameters:
//   WAIT_CYC  cycles from request accept to status capture (1..15)
//   CNT_W     statistics counter width (only used with BCU_STATS_EN)
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake
//   req_cond[3:0]           condition code
//   req_pc[31:0]            PC of the branch
//   req_off[31:0]           sign-extended word offset
//   status[2:0]             ALU flags {Z, N, V}
//   resp_valid/resp_ready   response handshake
//   resp_taken              branch taken
//   resp_next_pc[31:0]      next PC (target if taken, else pc+4)
//   resp_err                illegal condition code
//   stat_req, stat_taken    completed / taken counters (BCU_STATS_EN)
//   dbg_state[1:0]          FSM state: 0 IDLE, 1 WAIT, 2 EVAL, 3 RESP
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_off,
  input  logic [2:0]       status,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [31:0]      resp_next_pc,
  output logic             resp_err,
`ifdef BCU_STATS_EN
  output logic [CNT_W-1:0] stat_req,
  output logic [CNT_W-1:0] stat_taken,
`endif
  output logic [1:0]       dbg_state
);

  if (WAIT_CYC < 1 || WAIT_CYC > 15 || CNT_W < 1) begin : g_param_check
    $error("branch_cond_unit: WAIT_CYC must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cond_q, cond_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] off_q, off_d;
  logic        z_q, z_d, n_q, n_d, v_q, v_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_taken_q, resp_taken_d;
  logic [31:0] resp_next_pc_q, resp_next_pc_d;
  logic        resp_err_q, resp_err_d;

  logic        lt;
  logic        cond_true;
  logic        cond_err;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;
  logic        resp_hs;

  // Condition evaluation on the captured flags. lt is the signed less-than
  // of the preceding compare (N xor V).
  always_comb begin
    lt        = n_q ^ v_q;
    cond_true = 1'b0;
    cond_err  = 1'b0;
    case (cond_q)
      4'h0:    cond_true = z_q;
      4'h1:    cond_true = ~z_q;
      4'h2:    cond_true = lt;
      4'h3:    cond_true = ~lt;
      4'h4:    cond_true = z_q | lt;
      4'h5:    cond_true = ~z_q & ~lt;
      4'h6:    cond_true = v_q;
      4'h7:    cond_true = ~v_q;
      4'h8:    cond_true = n_q;
      4'h9:    cond_true = ~n_q;
      4'hA:    cond_true = 1'b1;
      4'hB:    cond_true = 1'b0;
      default: cond_err  = 1'b1;
    endcase
  end

  // Modulo-2^32 arithmetic. The shift drops offset bits [31:30].
  assign seq_pc  = pc_q + 32'd4;
  assign tgt_pc  = seq_pc + (off_q << 2);
  assign resp_hs = (state_q == S_RESP) && resp_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cond_d         = cond_q;
    pc_d           = pc_q;
    off_d          = off_q;
    z_d            = z_q;
    n_d            = n_q;
    v_d            = v_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_taken_d   = resp_taken_q;
    resp_next_pc_d = resp_next_pc_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          cond_d      = req_cond;
          pc_d        = req_pc;
          off_d       = req_off;
          cnt_d       = CNT_LOAD;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // status is looked at only on the edge where the count expires.
        if (cnt_q == 4'd0) begin
          z_d     = status[2];
          n_d     = status[1];
          v_d     = status[0];
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_EVAL: begin
        resp_taken_d   = cond_true & ~cond_err;
        resp_err_d     = cond_err;
        resp_next_pc_d = (cond_true & ~cond_err) ? tgt_pc : seq_pc;
        resp_valid_d   = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      cond_q         <= 4'd0;
      pc_q           <= 32'd0;
      off_q          <= 32'd0;
      z_q            <= 1'b0;
      n_q            <= 1'b0;
      v_q            <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_taken_q   <= 1'b0;
      resp_next_pc_q <= 32'd0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cond_q         <= cond_d;
      pc_q           <= pc_d;
      off_q          <= off_d;
      z_q            <= z_d;
      n_q            <= n_d;
      v_q            <= v_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_taken_q   <= resp_taken_d;
      resp_next_pc_q <= resp_next_pc_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_taken   = resp_taken_q;
  assign resp_next_pc = resp_next_pc_q;
  assign resp_err     = resp_err_q;
  assign dbg_state    = state_q;

`ifdef BCU_STATS_EN
  logic [CNT_W-1:0] stat_req_q, stat_req_d;
  logic [CNT_W-1:0] stat_taken_q, stat_taken_d;

  // Saturating counters. They are updated only on a response transfer.
  always_comb begin
    stat_req_d   = stat_req_q;
    stat_taken_d = stat_taken_q;
    if (resp_hs) begin
      if (stat_req_q != {CNT_W{1'b1}}) begin
        stat_req_d = stat_req_q + 1'b1;
      end
      if (resp_taken_q && (stat_taken_q != {CNT_W{1'b1}})) begin
        stat_taken_d = stat_taken_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_q   <= '0;
      stat_taken_q <= '0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_taken_q <= stat_taken_d;
    end
  end

  assign stat_req   = stat_req_q;
  assign stat_taken = stat_taken_q;
`else
  logic unused_hs;
  assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_unit
//
// Two instances share the request payload and status inputs:
//   dut_a : WAIT_CYC = 1 (default latency)
//   dut_b : WAIT_CYC = 3, CNT_W = 2 (latency stretch and counter saturation)
// Each instance has its own req_valid / resp_ready. The driver pushes the
// hand-computed response into a per-instance queue. A monitor pops and
// compares on every response transfer.
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;

  localparam int WAIT_A = 1;
  localparam int WAIT_B = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_cond;
  logic [31:0] req_pc;
  logic [31:0] req_off;
  logic [2:0]  status;

  logic        req_valid    [2];
  logic        resp_ready   [2];
  logic        req_ready    [2];
  logic        resp_valid   [2];
  logic        resp_taken   [2];
  logic [31:0] resp_next_pc [2];
  logic        resp_err     [2];
  logic [1:0]  dbg_state    [2];
`ifdef BCU_STATS_EN
  logic [15:0] stat_req_a, stat_taken_a;
  logic [1:0]  stat_req_b, stat_taken_b;
`endif

  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_hs [2] = '{0, 0};
  int n_tk [2] = '{0, 0};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_cond_unit #(.WAIT_CYC(WAIT_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cond(req_cond), .req_pc(req_pc), .req_off(req_off), .status(status),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_taken(resp_taken[0]), .resp_next_pc(resp_next_pc[0]),
    .resp_err(resp_err[0]),
`ifdef BCU_STATS_EN
    .stat_req(stat_req_a), .stat_taken(stat_taken_a),
`endif
    .dbg_state(dbg_state[0])
  );

  branch_cond_unit #(.WAIT_CYC(WAIT_B), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cond(req_cond), .req_pc(req_pc), .req_off(req_off), .status(status),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_taken(resp_taken[1]), .resp_next_pc(resp_next_pc[1]),
    .resp_err(resp_err[1]),
`ifdef BCU_STATS_EN
    .stat_req(stat_req_b), .stat_taken(stat_taken_b),
`endif
    .dbg_state(dbg_state[1])
  );

  // ---------------- compare helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int s);
    logic [33:0] e;
    if (resp_valid[s] && resp_ready[s]) begin
      if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp dut%0d: got a response with none expected", s);
      end else begin
        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("taken_dut%0d", s), {31'd0, resp_taken[s]}, {31'd0, e[33]});
        chk($sformatf("err_dut%0d", s), {31'd0, resp_err[s]}, {31'd0, e[32]});
        chk($sformatf("next_pc_dut%0d", s), resp_next_pc[s], e[31:0]);
        n_hs[s]++;
        if (e[33]) n_tk[s]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- driver ----------------
  // hold < 0 : resp_ready is raised before the request (it must be ignored
  //            until the response is pending)
  // hold > 0 : resp_ready is held low for hold cycles while the status inputs
  //            are toggled
  task automatic send(input int s, input logic [3:0] c, input logic [31:0] pc,
                      input logic [31:0] off, input logic [2:0] st,
                      input logic e_t, input logic e_e, input logic [31:0] e_pc,
                      input int hold);
    int n;
    int lat;
    n = 0;
    while (!req_ready[s] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_idle", {31'd0, req_ready[s]}, 32'd1);
    if (hold < 0) resp_ready[s] = 1'b1;
    req_cond     = c;
    req_pc       = pc;
    req_off      = off;
    status       = st;
    req_valid[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    if (s == 0) exp_q0.push_back({e_t, e_e, e_pc});
    else        exp_q1.push_back({e_t, e_e, e_pc});
    lat = 0;
    while (!resp_valid[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, ((s == 0) ? WAIT_A : WAIT_B) + 1);
    for (int i = 0; i < hold; i++) begin
      status = ~st;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid[s]}, 32'd1);
      chk("hold_pc", resp_next_pc[s], e_pc);
      chk("hold_taken", {31'd0, resp_taken[s]}, {31'd0, e_t});
      chk("hold_req_ready", {31'd0, req_ready[s]}, 32'd0);
    end
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
    chk("post_valid", {31'd0, resp_valid[s]}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready[s]}, 32'd1);
    chk("post_pc_kept", resp_next_pc[s], e_pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_valid;
    rst_n = 1'b0;
    req_cond = 4'd0; req_pc = 32'd0; req_off = 32'd0; status = 3'd0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      resp_ready[s] = 1'b0;
    end
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", {31'd0, req_ready[s]}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid[s]}, 32'd0);
      chk("rst_next_pc", resp_next_pc[s], 32'd0);
      chk("rst_taken", {31'd0, resp_taken[s]}, 32'd0);
      chk("rst_err", {31'd0, resp_err[s]}, 32'd0);
      chk("rst_state", {30'd0, dbg_state[s]}, 32'd0);
    end

    // Reset while dut_b is waiting for status: the transaction is dropped.
    req_cond = 4'hA; req_pc = 32'h40; req_off = 32'd1;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_wait", {30'd0, dbg_state[1]}, 32'd1);
    rst_n = 1'b0;
    #3;
    chk("midrst_state", {30'd0, dbg_state[1]}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready[1]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid[1]) seen_valid = 1'b1;
    end
    chk("midrst_no_resp", {31'd0, seen_valid}, 32'd0);

    // dut_a, WAIT_CYC = 1
    send(0, 4'h0, 32'h0000_0100, 32'h0000_0004, 3'b100, 1'b1, 1'b0, 32'h0000_0114, -1); // EQ
    send(0, 4'h2, 32'h0000_2000, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b0, 32'h0000_2000, 0);  // LT via V
    send(0, 4'h2, 32'h0000_2000, 32'hFFFF_FFFF, 3'b011, 1'b0, 1'b0, 32'h0000_2004, 0);  // LT false
    send(0, 4'h5, 32'h0000_0040, 32'h0000_0008, 3'b000, 1'b1, 1'b0, 32'h0000_0064, 5);  // GT, backpressure
    send(0, 4'hA, 32'hFFFF_FFFC, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 32'h0000_0000, 0);  // AL wrap
    send(0, 4'hD, 32'h0000_0300, 32'h0000_0005, 3'b111, 1'b0, 1'b1, 32'h0000_0304, 0);  // illegal
    send(0, 4'h1, 32'h0000_0500, 32'h0000_0010, 3'b100, 1'b0, 1'b0, 32'h0000_0504, 0);  // NE false
    send(0, 4'hA, 32'h0000_1000, 32'hC000_0001, 3'b000, 1'b1, 1'b0, 32'h0000_1008, 0);  // off[31:30] dropped
    send(0, 4'h8, 32'h0000_0000, 32'h3FFF_FFFF, 3'b010, 1'b1, 1'b0, 32'h0000_0000, 0);  // MI, target wraps
    send(0, 4'hB, 32'h0000_0010, 32'h0000_0004, 3'b111, 1'b0, 1'b0, 32'h0000_0014, 0);  // NV
    send(0, 4'h4, 32'h0000_0020, 32'h0000_0004, 3'b011, 1'b0, 1'b0, 32'h0000_0024, 0);  // LE false
    send(0, 4'h6, 32'h0000_0030, 32'h0000_0001, 3'b001, 1'b1, 1'b0, 32'h0000_0038, 0);  // VS
    send(0, 4'h7, 32'h0000_0030, 32'h0000_0001, 3'b001, 1'b0, 1'b0, 32'h0000_0034, 0);  // VC false
    send(0, 4'h9, 32'h0000_0000, 32'h0000_0002, 3'b000, 1'b1, 1'b0, 32'h0000_000C, 0);  // PL
    send(0, 4'h3, 32'h0000_0080, 32'h0000_0010, 3'b011, 1'b1, 1'b0, 32'h0000_00C4, 2);  // GE
    send(0, 4'hF, 32'h0000_0090, 32'h0000_0008, 3'b100, 1'b0, 1'b1, 32'h0000_0094, 0);  // illegal

    // dut_b, WAIT_CYC = 3
    send(1, 4'hA, 32'h0000_0100, 32'h0000_0001, 3'b000, 1'b1, 1'b0, 32'h0000_0108, 0);  // AL
    send(1, 4'hC, 32'h0000_0010, 32'h0000_0004, 3'b111, 1'b0, 1'b1, 32'h0000_0014, 0);  // illegal
    send(1, 4'h0, 32'h0000_0000, 32'h0000_0000, 3'b100, 1'b1, 1'b0, 32'h0000_0004, 3);  // EQ
    send(1, 4'h0, 32'h0000_0000, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 32'h0000_0004, 0);  // EQ false
    send(1, 4'h2, 32'h0000_0008, 32'h0000_0003, 3'b010, 1'b1, 1'b0, 32'h0000_0018, 0);  // LT via N

    @(posedge clk); #1;
`ifdef BCU_STATS_EN
    chk("stat_req_a", {16'd0, stat_req_a}, n_hs[0]);
    chk("stat_taken_a", {16'd0, stat_taken_a}, n_tk[0]);
    chk("stat_req_b_sat", {30'd0, stat_req_b}, (n_hs[1] > 3) ? 3 : n_hs[1]);
    chk("stat_taken_b_sat", {30'd0, stat_taken_b}, (n_tk[1] > 3) ? 3 : n_tk[1]);
`endif
    chk("queue_a_empty", exp_q0.size(), 32'd0);
    chk("queue_b_empty", exp_q1.size(), 32'd0);
    chk("responses_a", n_hs[0], 32'd16);
    chk("responses_b", n_hs[1], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer of the ALU status flags (Z, N, V). The ALU latches these flags on the falling clock edge.
- Accepts a conditional-branch request (condition code, PC, word offset) and waits for the status of the compare that the datapath issued in the same cycle.
- Evaluates the condition and returns taken/not-taken plus the next PC over a valid/ready handshake.
- Sits between the ALU status register and the PC-update logic.

Parameters:
- WAIT_CYC, 1, number of clock cycles from request accept to status capture; legal range 1..15.
- CNT_W, 16, width of the statistics counters; used only with BCU_STATS_EN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  branch request present.
- req_ready  output  1  unit can accept a request.
- req_cond  input  4  condition code.
- req_pc  input  32  PC of the branch instruction.
- req_off  input  32  sign-extended word offset.
- status  input  3  ALU flags: [2]=Z, [1]=N, [0]=V.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_taken  output  1  branch taken.
- resp_next_pc  output  32  next PC.
- resp_err  output  1  illegal condition code.
- stat_req  output  CNT_W  requests completed (BCU_STATS_EN only).
- stat_taken  output  CNT_W  taken branches (BCU_STATS_EN only).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_taken=0, resp_next_pc=0, resp_err=0.
  - Internal captures and wait counter = 0.
  - Reset asserted mid-operation aborts the transaction; no response is produced.
- States: IDLE, WAIT, EVAL, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid&req_ready at edge T: capture cond, pc, off; load counter=WAIT_CYC-1; go to WAIT.
- WAIT:
  - Each edge, decrement the counter.
  - At the edge where counter==0 (edge T+WAIT_CYC): capture status into z/n/v; go to EVAL.
  - status is sampled only at that edge; changes at other times are ignored.
- EVAL:
  - At edge T+WAIT_CYC+1: register resp_taken, resp_next_pc and resp_err; set resp_valid=1; go to RESP.
  - Default latency: resp_valid is high 2 cycles after the accept edge.
- RESP:
  - Outputs held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid&resp_ready: resp_valid=0, go to IDLE. Outputs other than resp_valid keep their last values.
  - No request is accepted in the same cycle as a response handshake; the earliest next accept is the following cycle.
  - resp_ready is ignored outside RESP.
- Condition codes (lt = n^v):
  - 0000 EQ: z
  - 0001 NE: !z
  - 0010 LT: lt
  - 0011 GE: !lt
  - 0100 LE: z|lt
  - 0101 GT: !z&!lt
  - 0110 VS: v
  - 0111 VC: !v
  - 1000 MI: n
  - 1001 PL: !n
  - 1010 AL: 1
  - 1011 NV: 0
  - 1100..1111: illegal, so taken=0 and resp_err=1.
- Arithmetic, all modulo 2^32 (wrap-around, no error):
  - seq = pc + 4.
  - tgt = pc + 4 + (off << 2); off bits [31:30] are discarded by the shift.
  - resp_next_pc = taken ? tgt : seq.

Optional Feature:
- Macro: BCU_STATS_EN.
- Defined:
  - stat_req and stat_taken are present.
  - Both counters reset to 0.
  - stat_req increments on each response handshake; stat_taken increments on each handshake with resp_taken=1.
  - Both counters saturate at all-ones (no wrap).
- Undefined: both ports and all counter logic are absent.

Test Plan:
- Reset then idle: after rst_n release, req_ready=1, resp_valid=0, resp_next_pc=0. Assert rst_n=0 while in WAIT, then release: state returns to IDLE, resp_valid is never asserted.
- EQ taken: cond=0000, pc=0x100, off=0x4, status=3'b100 at capture edge. Response: taken=1, next_pc=0x114, err=0, resp_valid high 2 cycles after accept.
- LT signed via overflow: cond=0010, status=3'b001 (N=0, V=1) gives taken=1. status=3'b011 gives taken=0 and next_pc=pc+4.
- Backpressure and sampling: hold resp_ready=0 for 5 cycles; outputs stay stable and req_ready=0. Toggle status after the capture edge; result is unchanged. Raise resp_ready; handshake, then accept a new request the next cycle.
- Wrap and illegal code: pc=0xFFFFFFFC, cond=1010, off=0 gives next_pc=0x00000000. cond=1101 gives taken=0, err=1, next_pc=pc+4. With WAIT_CYC=3, resp_valid rises 4 cycles after accept.
- With BCU_STATS_EN, 3 taken and 2 not-taken handshakes give stat_req=5, stat_taken=3. With CNT_W=2, 5 requests give stat_req=3 (saturated).
